// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   master : operand source and result consumer (drives in_valid, operands,
//            command, out_ready)
//   slave  : the ALU pipeline (drives in_ready, out_valid, result, flags)
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [2:0]       command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, operand_a, operand_b, command, out_ready,
        input  in_ready, out_valid, result, carryout, zero, overflow
    );

    modport slave (
        input  in_valid, operand_a, operand_b, command, out_ready,
        output in_ready, out_valid, result, carryout, zero, overflow
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   bus (slave)     : operand beat in (in_valid/in_ready, operand_a/b,
//                     command), result beat out (out_valid/out_ready,
//                     result, carryout, zero, overflow)
//   clear_flags     : synchronous clear of overflow_sticky (set wins)
//   overflow_sticky : set by any accepted result beat with overflow=1
//   op_count        : accepted result beats, modulo 2^COUNT_W
// S1 holds captured operands/command; S2 holds the computed result and flags.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_pipe_if.slave          bus,
    input  logic               clear_flags,
    output logic               overflow_sticky,
    output logic [COUNT_W-1:0] op_count
);
    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } alu_res_t;

    // One shared adder serves ADD, SUB and SLT; SUB/SLT invert B and inject
    // a carry-in. SLT takes sign XOR overflow so it stays correct when the
    // subtraction wraps.
    function automatic alu_res_t alu_eval(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic [2:0]              cmd
    );
        alu_res_t         r;
        logic             sub;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH:0]   sum;
        logic             c_msb_in;
        logic             ovf;
        sub      = (cmd == CMD_SUB) || (cmd == CMD_SLT);
        b_eff    = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        c_msb_in = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
        ovf      = c_msb_in ^ sum[WIDTH];
        r        = '0;
        case (cmd)
            CMD_ADD, CMD_SUB: begin
                r.res   = sum[WIDTH-1:0];
                r.carry = sum[WIDTH];
                r.ovf   = ovf;
            end
            CMD_SLT:  r.res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            CMD_XOR:  r.res = a ^ b;
            CMD_AND:  r.res = a & b;
            CMD_NAND: r.res = ~(a & b);
            CMD_NOR:  r.res = ~(a | b);
            CMD_OR:   r.res = a | b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    logic                    vld_p1;
    logic signed [WIDTH-1:0] a_p1;
    logic signed [WIDTH-1:0] b_p1;
    logic [2:0]              cmd_p1;
    logic                    vld_p2;
    logic [WIDTH-1:0]        result_p2;
    logic                    carry_p2;
    logic                    zero_p2;
    logic                    ovf_p2;
    logic                    adv_p1;
    logic                    accept;
    logic                    fire;
    alu_res_t                eval_p1;

    assign adv_p1       = vld_p1 && (!vld_p2 || bus.out_ready);
    // Combinational from out_ready so a full pipe can still take a beat
    // on the same cycle its output drains.
    assign bus.in_ready = !reset && (!vld_p1 || adv_p1);
    assign accept       = bus.in_valid && bus.in_ready;
    assign fire         = vld_p2 && bus.out_ready;
    assign eval_p1      = alu_eval(a_p1, b_p1, cmd_p1);

    // ---- Stage 1: operand capture ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (adv_p1) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= bus.operand_a;
            b_p1   <= bus.operand_b;
            cmd_p1 <= bus.command;
        end
    end

    // ---- Stage 2: result and flags ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            carry_p2  <= 1'b0;
            zero_p2   <= 1'b0;
            ovf_p2    <= 1'b0;
        end else if (adv_p1) begin
            vld_p2    <= 1'b1;
            result_p2 <= eval_p1.res;
            carry_p2  <= eval_p1.carry;
            zero_p2   <= (eval_p1.res == '0);
            ovf_p2    <= eval_p1.ovf;
        end else if (fire) begin
            vld_p2    <= 1'b0;
        end
    end

    // ---- Output side: sticky overflow and completion counter ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_sticky <= 1'b0;
            op_count        <= '0;
        end else begin
            if (fire && ovf_p2) begin
                overflow_sticky <= 1'b1;
            end else if (clear_flags) begin
                overflow_sticky <= 1'b0;
            end
            if (fire) begin
                op_count <= op_count + COUNT_W'(1);
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.result    = result_p2;
    assign bus.carryout  = carry_p2;
    assign bus.zero      = zero_p2;
    assign bus.overflow  = ovf_p2;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (32-bit/16-bit-count and
// 8-bit/2-bit-count instances) against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, rst8, clr32, clr8, sticky32, sticky8;
    logic [15:0] cnt32;
    logic [1:0]  cnt8;

    alu_pipe_if #(.WIDTH(32)) b32 ();
    alu_pipe_if #(.WIDTH(8))  b8 ();

    alu_pipe #(.WIDTH(32), .COUNT_W(16)) dut32 (
        .clk(clk), .reset(rst32), .bus(b32), .clear_flags(clr32),
        .overflow_sticky(sticky32), .op_count(cnt32)
    );
    alu_pipe #(.WIDTH(8), .COUNT_W(2)) dut8 (
        .clk(clk), .reset(rst8), .bus(b8), .clear_flags(clr8),
        .overflow_sticky(sticky8), .op_count(cnt8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sa_q[$];
    logic [31:0] sb_q[$];
    logic [2:0]  sc_q[$];
    logic [31:0] gr_q[$];
    logic        gc_q[$];
    logic        gz_q[$];
    logic        gv_q[$];
    int          lat_q[$];
    int          acc_q[$];
    int          hold_err;
    bit          saw_block;
    int          block_at;
    bit          timed_out;

    // Reference model: signed/unsigned arithmetic on 64-bit integers.
    function automatic void model(input int w, input longint unsigned a,
                                  input longint unsigned b, input logic [2:0] cmd,
                                  output longint unsigned res, output logic c,
                                  output logic z, output logic v);
        longint unsigned mask, full;
        longint sa, sb, s, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        sa   = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb   = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        res = 0; c = 0; v = 0;
        case (cmd)
            3'd0: begin
                full = a + b; res = full & mask; c = ((full >> w) & 64'd1) != 0;
                s = sa + sb; v = (s > smax) || (s < smin);
            end
            3'd1: begin
                full = a + ((~b) & mask) + 64'd1; res = full & mask;
                c = ((full >> w) & 64'd1) != 0;
                s = sa - sb; v = (s > smax) || (s < smin);
            end
            3'd2: res = a ^ b;
            3'd3: res = (sa < sb) ? 64'd1 : 64'd0;
            3'd4: res = a & b;
            3'd5: res = (~(a & b)) & mask;
            3'd6: res = (~(a | b)) & mask;
            default: res = a | b;
        endcase
        z = (res == 0);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic push_beat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        sa_q.push_back(a); sb_q.push_back(b); sc_q.push_back(c);
    endtask

    task automatic clear_stim();
        sa_q.delete(); sb_q.delete(); sc_q.delete();
    endtask

    // Streams the queued beats into dut32 and records every accepted result.
    task automatic drive32(input int budget, input int stall_from, input int stall_len,
                           input bit rand_ready, input bit rand_valid);
        int cyc, sent;
        bit prev_stall;
        logic [31:0] prev_res;
        logic [2:0]  prev_flags;
        cyc = 0; sent = 0; prev_stall = 0; prev_res = '0; prev_flags = '0;
        gr_q.delete(); gc_q.delete(); gz_q.delete(); gv_q.delete();
        lat_q.delete(); acc_q.delete();
        hold_err = 0; saw_block = 0; block_at = -1;
        while (gr_q.size() < sa_q.size() && cyc < budget) begin
            @(negedge clk);
            if (prev_stall && (b32.out_valid !== 1'b1 || b32.result !== prev_res ||
                {b32.carryout, b32.zero, b32.overflow} !== prev_flags))
                hold_err++;
            if (rand_ready) b32.out_ready = 1'($urandom_range(0, 1));
            else b32.out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (sent < sa_q.size() && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                b32.in_valid = 1'b1;
                b32.operand_a = sa_q[sent]; b32.operand_b = sb_q[sent]; b32.command = sc_q[sent];
            end else begin
                b32.in_valid = 1'b0;
                b32.operand_a = $urandom(); b32.operand_b = $urandom();
                b32.command = 3'($urandom_range(0, 7));
            end
            #1;
            if (b32.in_valid && !b32.in_ready && !saw_block) begin
                saw_block = 1; block_at = sent;
            end
            if (b32.out_valid && b32.out_ready) begin
                gr_q.push_back(b32.result); gc_q.push_back(b32.carryout);
                gz_q.push_back(b32.zero); gv_q.push_back(b32.overflow);
                if (acc_q.size() >= gr_q.size()) lat_q.push_back(cyc - acc_q[gr_q.size() - 1]);
                else lat_q.push_back(-1);
            end
            if (b32.in_valid && b32.in_ready) begin
                acc_q.push_back(cyc); sent++;
            end
            prev_stall = b32.out_valid && !b32.out_ready;
            prev_res   = b32.result;
            prev_flags = {b32.carryout, b32.zero, b32.overflow};
            cyc++;
        end
        timed_out = (gr_q.size() < sa_q.size());
        @(negedge clk);
        b32.in_valid = 1'b0; b32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_tests++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
        n_tests++; if (b32.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", b32.result); end
        n_tests++; if ({b32.carryout, b32.zero, b32.overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {b32.carryout, b32.zero, b32.overflow}); end
        n_tests++; if (sticky32 !== 1'b0 || cnt32 !== 16'h0) begin n_fail++; $display("FAIL reset_sticky_count: got %b/%h want 0/0", sticky32, cnt32); end
        n_tests++; if (b32.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", b32.in_ready); end
        rst32 = 1'b0;
        #1;
        n_tests++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high: got %b want 1", b32.in_ready); end
    endtask

    task automatic test_add_basic();
        clear_stim();
        push_beat(32'h0, 32'h0, 3'd0);
        push_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0);
        drive32(50, -1, 0, 0, 0);
        n_tests++;
        if (gr_q.size() != 2) begin
            n_fail++; $display("FAIL add_count: got %0d beats want 2", gr_q.size());
        end else begin
            n_tests++; if ({gr_q[0], gz_q[0], gc_q[0], gv_q[0]} !== {32'h0, 3'b100}) begin n_fail++; $display("FAIL add_zero: got %h z%b c%b v%b want 0 z1 c0 v0", gr_q[0], gz_q[0], gc_q[0], gv_q[0]); end
            n_tests++; if ({gr_q[1], gz_q[1], gc_q[1], gv_q[1]} !== {32'hFFFF_FFFE, 3'b010}) begin n_fail++; $display("FAIL add_max: got %h z%b c%b v%b want FFFFFFFE z0 c1 v0", gr_q[1], gz_q[1], gc_q[1], gv_q[1]); end
            n_tests++; if (lat_q[0] !== 2 || lat_q[1] !== 2) begin n_fail++; $display("FAIL add_latency: got %0d,%0d want 2,2", lat_q[0], lat_q[1]); end
        end
    endtask

    task automatic test_sub_overflow();
        clear_stim();
        push_beat(32'd300, 32'd100, 3'd1);
        push_beat(32'd100, 32'd300, 3'd1);
        drive32(50, -1, 0, 0, 0);
        n_tests++;
        if (gr_q.size() != 2) begin
            n_fail++; $display("FAIL sub_count: got %0d beats want 2", gr_q.size());
        end else begin
            n_tests++; if ({gr_q[0], gc_q[0], gv_q[0]} !== {32'd200, 2'b10}) begin n_fail++; $display("FAIL sub_pos: got %h c%b v%b want C8 c1 v0", gr_q[0], gc_q[0], gv_q[0]); end
            n_tests++; if ({gr_q[1], gc_q[1], gv_q[1]} !== {32'hFFFF_FF38, 2'b00}) begin n_fail++; $display("FAIL sub_neg: got %h c%b v%b want FFFFFF38 c0 v0", gr_q[1], gc_q[1], gv_q[1]); end
        end
        n_tests++; if (sticky32 !== 1'b0) begin n_fail++; $display("FAIL sticky_before: got %b want 0", sticky32); end
        clear_stim();
        push_beat(32'h7FFF_FFFF, 32'h1, 3'd0);
        drive32(50, -1, 0, 0, 0);
        n_tests++;
        if (gr_q.size() != 1 || {gr_q[0], gv_q[0]} !== {32'h8000_0000, 1'b1}) begin
            n_fail++; $display("FAIL add_ovf: got %0d beats want 80000000 v1", gr_q.size());
        end
        n_tests++; if (sticky32 !== 1'b1) begin n_fail++; $display("FAIL sticky_set: got %b want 1", sticky32); end
    endtask

    task automatic test_logic_slt();
        logic [31:0] ea[8];
        logic [31:0] eb[8];
        logic [2:0]  ec[8];
        logic [31:0] er[8];
        ea = '{32'h11C, 32'h11C, 32'h11C, 32'h11C, 32'h11C, 32'h11C, 32'h8000_0000, 32'd200};
        eb = '{32'h1FF, 32'h1FF, 32'h1FF, 32'h1FF, 32'h1FF, 32'h1FF, 32'h1, 32'd100};
        ec = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd3, 3'd3};
        er = '{32'h0E3, 32'h11C, 32'hFFFF_FEE3, 32'hFFFF_FE00, 32'h1FF, 32'h1, 32'h1, 32'h0};
        clear_stim();
        for (int i = 0; i < 8; i++) push_beat(ea[i], eb[i], ec[i]);
        drive32(80, -1, 0, 0, 0);
        n_tests++;
        if (gr_q.size() != 8) begin
            n_fail++; $display("FAIL logic_count: got %0d beats want 8", gr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if ({gr_q[i], gc_q[i], gv_q[i], gz_q[i]} !== {er[i], 2'b00, (er[i] == 32'h0)}) begin
                    n_fail++; $display("FAIL logic_op%0d: got %h c%b v%b z%b want %h c0 v0", i, gr_q[i], gc_q[i], gv_q[i], gz_q[i], er[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        longint unsigned r; logic c, z, v;
        @(negedge clk); rst32 = 1'b1;
        @(negedge clk); rst32 = 1'b0;
        clear_stim();
        for (int i = 0; i < 5; i++) push_beat($urandom(), $urandom(), 3'd0);
        drive32(60, 2, 3, 0, 0);
        n_tests++; if (saw_block !== 1'b1 || block_at !== 2) begin n_fail++; $display("FAIL bp_in_ready: got block=%b at %0d want 1 at 2", saw_block, block_at); end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes want 0", hold_err); end
        n_tests++;
        if (gr_q.size() != 5) begin
            n_fail++; $display("FAIL bp_count: got %0d beats want 5", gr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                model(32, 64'(sa_q[i]), 64'(sb_q[i]), sc_q[i], r, c, z, v);
                n_tests++; if (gr_q[i] !== 32'(r) || gc_q[i] !== c) begin n_fail++; $display("FAIL bp_beat%0d: got %h c%b want %h c%b", i, gr_q[i], gc_q[i], 32'(r), c); end
            end
        end
        n_tests++; if (cnt32 !== 16'd5) begin n_fail++; $display("FAIL bp_op_count: got %0d want 5", cnt32); end
    endtask

    task automatic test_random();
        longint unsigned r; logic c, z, v;
        logic [15:0] start;
        int errs;
        start = cnt32;
        clear_stim();
        for (int i = 0; i < 300; i++) push_beat(pick32(), pick32(), 3'($urandom_range(0, 7)));
        drive32(5000, -1, 0, 1, 1);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: got %0d beats want 300", gr_q.size()); end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL rand_hold: got %0d changes want 0", hold_err); end
        errs = 0;
        for (int i = 0; i < gr_q.size(); i++) begin
            model(32, 64'(sa_q[i]), 64'(sb_q[i]), sc_q[i], r, c, z, v);
            n_tests++;
            if ({gr_q[i], gc_q[i], gz_q[i], gv_q[i]} !== {32'(r), c, z, v}) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_beat%0d cmd%0d: got %h c%b z%b v%b want %h c%b z%b v%b", i, sc_q[i], gr_q[i], gc_q[i], gz_q[i], gv_q[i], 32'(r), c, z, v);
            end
        end
        n_tests++; if (cnt32 !== 16'(start + 16'd300)) begin n_fail++; $display("FAIL rand_op_count: got %0d want %0d", cnt32, 16'(start + 16'd300)); end
    endtask

    task automatic test_sticky_clear();
        int waited;
        @(negedge clk); clr32 = 1'b1;
        @(negedge clk); clr32 = 1'b0;
        n_tests++; if (sticky32 !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b want 0", sticky32); end
        b32.out_ready = 1'b0; b32.in_valid = 1'b1;
        b32.operand_a = 32'h7FFF_FFFF; b32.operand_b = 32'h1; b32.command = 3'd0;
        @(negedge clk); b32.in_valid = 1'b0;
        waited = 0;
        while (b32.out_valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        n_tests++; if (b32.out_valid !== 1'b1) begin n_fail++; $display("FAIL sticky_wait: got out_valid %b want 1", b32.out_valid); end
        b32.out_ready = 1'b1; clr32 = 1'b1;
        @(negedge clk); b32.out_ready = 1'b0; clr32 = 1'b0;
        n_tests++; if (sticky32 !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b want 1", sticky32); end
        @(negedge clk);
        n_tests++; if (sticky32 !== 1'b1) begin n_fail++; $display("FAIL sticky_holds: got %b want 1", sticky32); end
        clr32 = 1'b1;
        @(negedge clk); clr32 = 1'b0;
        n_tests++; if (sticky32 !== 1'b0) begin n_fail++; $display("FAIL sticky_clear2: got %b want 0", sticky32); end
    endtask

    task automatic test_width8();
        int waited;
        bit stale;
        @(negedge clk); rst8 = 1'b0; b8.out_ready = 1'b1;
        b8.in_valid = 1'b1; b8.operand_a = 8'h7F; b8.operand_b = 8'h01; b8.command = 3'd0;
        @(negedge clk); b8.in_valid = 1'b0;
        waited = 0;
        while (b8.out_valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        n_tests++;
        if ({b8.out_valid, b8.result, b8.overflow, b8.carryout, b8.zero} !== {1'b1, 8'h80, 3'b100}) begin
            n_fail++; $display("FAIL w8_add: got vld%b %h v%b c%b z%b want 80 v1 c0 z0", b8.out_valid, b8.result, b8.overflow, b8.carryout, b8.zero);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b8.in_valid = 1'b1; b8.operand_a = 8'($urandom()); b8.operand_b = 8'($urandom()); b8.command = 3'd0;
            @(negedge clk);
        end
        b8.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (cnt8 !== 2'd1) begin n_fail++; $display("FAIL w8_count_wrap: got %0d want 1", cnt8); end
        b8.out_ready = 1'b0;
        b8.in_valid = 1'b1; b8.operand_a = 8'h11; b8.operand_b = 8'h22;
        @(negedge clk); b8.operand_a = 8'h33;
        @(negedge clk); b8.in_valid = 1'b0;
        n_tests++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL w8_inflight: got out_valid %b want 1", b8.out_valid); end
        #2 rst8 = 1'b1;
        #1;
        n_tests++; if (b8.out_valid !== 1'b0 || cnt8 !== 2'd0) begin n_fail++; $display("FAIL w8_async_reset: got vld%b cnt%0d want 0/0", b8.out_valid, cnt8); end
        @(negedge clk); rst8 = 1'b0; b8.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin @(negedge clk); if (b8.out_valid !== 1'b0) stale = 1; end
        n_tests++; if (stale !== 1'b0 || cnt8 !== 2'd0) begin n_fail++; $display("FAIL w8_stale: got stale%b cnt%0d want 0/0", stale, cnt8); end
    endtask

    initial begin
        rst32 = 1'b1; rst8 = 1'b1; clr32 = 1'b0; clr8 = 1'b0;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.operand_a = '0; b32.operand_b = '0; b32.command = '0;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.operand_a = '0; b8.operand_b = '0; b8.command = '0;
        test_reset();
        test_add_basic();
        test_sub_overflow();
        test_logic_slt();
        test_backpressure();
        test_random();
        test_sticky_clear();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
